// File: rtl/mux_nway_reg.sv
// N-way registered multiplexer with valid/ready handshakes on every channel.
// The source is picked either by an explicit select or by round-robin arbitration.
module mux_nway_reg #(
   parameter int WIDTH = 16,
   parameter int WAYS  = 4,
   localparam int SEL_W = $clog2(WAYS)
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic                    mode,
   input  logic [SEL_W-1:0]        select,
   input  logic [WAYS*WIDTH-1:0]   in_data,
   input  logic [WAYS-1:0]         in_valid,
   output logic [WAYS-1:0]         in_ready,
   output logic [WIDTH-1:0]        out_data,
   output logic                    out_valid,
   input  logic                    out_ready,
   output logic [SEL_W-1:0]        out_chan
);

   typedef enum logic {
      MODE_SELECT = 1'b0,
      MODE_RR     = 1'b1
   } mode_e;

   logic [WIDTH-1:0] out_data_q,  out_data_d;
   logic             out_valid_q, out_valid_d;
   logic [SEL_W-1:0] out_chan_q,  out_chan_d;
   logic [SEL_W-1:0] ptr_q,       ptr_d;

   logic             load_en;
   logic [SEL_W-1:0] grant;
   logic             grant_ok;
   logic             xfer;
   logic [WIDTH-1:0] grant_data;
   mode_e            mode_sel;

   // Channel index reached k steps after base, wrapping at WAYS.
   function automatic logic [SEL_W-1:0] rr_idx(input logic [SEL_W-1:0] base, input int k);
      int s;
      s = int'(base) + k;
      if (s >= WAYS) s = s - WAYS;
      return SEL_W'(s);
   endfunction

   assign mode_sel = mode_e'(mode);

   // Reset is folded in here so no producer sees in_ready while the register is being cleared.
   assign load_en = (!out_valid_q || out_ready) && !reset;

   always_comb begin
      // NOTE: every output of a combinational block gets a default first; a path that
      // leaves one unassigned would infer a latch.
      grant    = '0;
      grant_ok = 1'b0;
      if (mode_sel == MODE_SELECT) begin
         grant    = select;
         grant_ok = (int'(select) < WAYS);
      end else begin
         for (int k = 0; k < WAYS; k++) begin
            if (!grant_ok && in_valid[rr_idx(ptr_q, k)]) begin
               grant    = rr_idx(ptr_q, k);
               grant_ok = 1'b1;
            end
         end
      end
   end

   always_comb begin
      in_ready = '0;
      if (grant_ok && load_en) in_ready[grant] = 1'b1;
   end

   assign xfer = grant_ok && load_en && in_valid[grant];

   always_comb begin
      grant_data = '0;
      for (int i = 0; i < WAYS; i++) begin
         if (SEL_W'(i) == grant) grant_data = in_data[i*WIDTH +: WIDTH];
      end
   end

   always_comb begin
      out_data_d  = out_data_q;
      out_valid_d = out_valid_q;
      out_chan_d  = out_chan_q;
      ptr_d       = ptr_q;
      if (xfer) begin
         out_data_d  = grant_data;
         out_chan_d  = grant;
         out_valid_d = 1'b1;
         // The pointer only moves on a round-robin transfer, so a stall never costs a channel its turn.
         if (mode_sel == MODE_RR) begin
            ptr_d = (grant == SEL_W'(WAYS - 1)) ? '0 : grant + 1'b1;
         end
      end else if (out_ready) begin
         out_valid_d = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      // NOTE: state registers use non-blocking assignments so every flop samples
      // values from before the edge, independent of statement order.
      if (reset) begin
         out_data_q  <= '0;
         out_valid_q <= 1'b0;
         out_chan_q  <= '0;
         ptr_q       <= '0;
      end else begin
         out_data_q  <= out_data_d;
         out_valid_q <= out_valid_d;
         out_chan_q  <= out_chan_d;
         ptr_q       <= ptr_d;
      end
   end

   assign out_data  = out_data_q;
   assign out_valid = out_valid_q;
   assign out_chan  = out_chan_q;

   a_ready_onehot: assert property (@(posedge clk) $onehot0(in_ready));

   a_hold_stable: assert property (@(posedge clk) disable iff (reset)
      (out_valid_q && !out_ready) |=> (out_valid_q && $stable(out_data_q) && $stable(out_chan_q)));

endmodule

// File: tb/tb_mux_nway_reg.sv
// Directed bench for mux_nway_reg: reset, explicit select, round-robin,
// backpressure and mid-stream reset, all with hand-computed expectations.
module tb_mux_nway_reg;

   localparam int WIDTH = 16;
   localparam int WAYS  = 4;
   localparam int SEL_W = 2;

   logic                  clk = 1'b0;
   logic                  reset;
   logic                  mode;
   logic [SEL_W-1:0]      select;
   logic [WAYS*WIDTH-1:0] in_data;
   logic [WAYS-1:0]       in_valid;
   logic [WAYS-1:0]       in_ready;
   logic [WIDTH-1:0]      out_data;
   logic                  out_valid;
   logic                  out_ready;
   logic [SEL_W-1:0]      out_chan;

   int n_total = 0;
   int n_bad   = 0;

   logic [WIDTH-1:0] words [WAYS] = '{16'hA0A0, 16'hB1B1, 16'hC2C2, 16'hD3D3};

   mux_nway_reg #(.WIDTH(WIDTH), .WAYS(WAYS)) dut (
      .clk       (clk),
      .reset     (reset),
      .mode      (mode),
      .select    (select),
      .in_data   (in_data),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .out_data  (out_data),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_chan  (out_chan)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_total++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic load_words();
      for (int i = 0; i < WAYS; i++) in_data[i*WIDTH +: WIDTH] = words[i];
   endtask

   initial begin
      reset     = 1'b1;
      mode      = 1'b1;
      select    = '0;
      in_valid  = 4'b1111;
      out_ready = 1'b1;
      load_words();

      // 1. Reset then idle
      tick();
      #1 check("rst_ready", 32'(in_ready), 32'h0);
      tick();
      check("rst_valid", 32'(out_valid), 32'h0);
      check("rst_data",  32'(out_data),  32'h0);
      check("rst_chan",  32'(out_chan),  32'h0);
      check("rst_ptr",   32'(dut.ptr_q), 32'h0);
      reset = 1'b0;
      #1 check("first_ready", 32'(in_ready), 32'h1);
      tick();
      check("first_valid", 32'(out_valid), 32'h1);
      check("first_data",  32'(out_data),  32'hA0A0);
      check("first_chan",  32'(out_chan),  32'h0);

      // 2. Mode 0 select sweep; ptr (now 1) must not move
      mode = 1'b0;
      for (int s = 0; s < WAYS; s++) begin
         select = SEL_W'(s);
         #1 check($sformatf("sel%0d_ready", s), 32'(in_ready), 32'(1 << s));
         tick();
         check($sformatf("sel%0d_data", s),  32'(out_data),  32'(words[s]));
         check($sformatf("sel%0d_chan", s),  32'(out_chan),  32'(s));
         check($sformatf("sel%0d_valid", s), 32'(out_valid), 32'h1);
      end
      check("sel_ptr_hold", 32'(dut.ptr_q), 32'h1);

      // 3. Round-robin fairness from ptr=0
      reset = 1'b1;
      tick();
      reset = 1'b0;
      mode  = 1'b1;
      for (int k = 0; k < 6; k++) begin
         #1 check($sformatf("rr%0d_ready", k), 32'(in_ready), 32'(1 << (k % 4)));
         tick();
         check($sformatf("rr%0d_chan", k), 32'(out_chan), 32'(k % 4));
         check($sformatf("rr%0d_data", k), 32'(out_data), 32'(words[k % 4]));
      end
      check("rr_ptr", 32'(dut.ptr_q), 32'h2);

      // 4. Skip and wrap: bring ptr to 3, then only channels 1 and 3 valid
      tick();
      check("wrap_pre_chan", 32'(out_chan), 32'h2);
      check("wrap_pre_ptr",  32'(dut.ptr_q), 32'h3);
      in_valid = 4'b1010;
      tick();
      check("wrap0_chan", 32'(out_chan), 32'h3);
      check("wrap0_ptr",  32'(dut.ptr_q), 32'h0);
      tick();
      check("wrap1_chan", 32'(out_chan), 32'h1);
      check("wrap1_ptr",  32'(dut.ptr_q), 32'h2);
      tick();
      check("wrap2_chan", 32'(out_chan), 32'h3);
      check("wrap2_ptr",  32'(dut.ptr_q), 32'h0);

      // 5. Backpressure while holding 0x1234 from channel 0
      in_data[0 +: WIDTH] = 16'h1234;
      in_valid = 4'b0001;
      tick();
      check("bp_load_data", 32'(out_data), 32'h1234);
      check("bp_load_ptr",  32'(dut.ptr_q), 32'h1);
      out_ready = 1'b0;
      in_valid  = 4'b1111;
      for (int c = 0; c < 3; c++) begin
         in_data[0 +: WIDTH] = 16'h5555 + 16'(c);
         #1 check($sformatf("bp%0d_ready", c), 32'(in_ready), 32'h0);
         tick();
         check($sformatf("bp%0d_data", c),  32'(out_data),  32'h1234);
         check($sformatf("bp%0d_valid", c), 32'(out_valid), 32'h1);
         check($sformatf("bp%0d_chan", c),  32'(out_chan),  32'h0);
         check($sformatf("bp%0d_ptr", c),   32'(dut.ptr_q), 32'h1);
      end
      load_words();
      out_ready = 1'b1;
      #1 check("bp_release_ready", 32'(in_ready), 32'h2);
      tick();
      check("bp_release_data",  32'(out_data),  32'hB1B1);
      check("bp_release_valid", 32'(out_valid), 32'h1);
      check("bp_release_chan",  32'(out_chan),  32'h1);

      // 6. Reset mid-stream while a word is held
      out_ready = 1'b0;
      tick();
      check("mid_hold_data", 32'(out_data), 32'hB1B1);
      reset = 1'b1;
      #1 check("mid_rst_ready", 32'(in_ready), 32'h0);
      tick();
      check("mid_rst_valid", 32'(out_valid), 32'h0);
      check("mid_rst_data",  32'(out_data),  32'h0);
      check("mid_rst_ptr",   32'(dut.ptr_q), 32'h0);
      reset = 1'b0;
      #1 check("mid_after_ready", 32'(in_ready), 32'h1);

      // Drain with no valid inputs: valid drops, data and channel hold
      tick();
      check("drain_load_data", 32'(out_data), 32'hA0A0);
      in_valid  = 4'b0000;
      out_ready = 1'b1;
      tick();
      check("drain_valid", 32'(out_valid), 32'h0);
      check("drain_data",  32'(out_data),  32'hA0A0);
      check("drain_chan",  32'(out_chan),  32'h0);

      $display("test done: total=%0d bad=%0d", n_total, n_bad);
      $finish;
   end

endmodule
